// File: rtl/pid_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
// Definitions shared between the PID core and its SPI front/back ends.
//   PV_W        process-value word width seen by the PID core
//   PV_CLK_DIV  default SPI clock half-period, in system clock cycles
//   pv_state_e  state encoding of the PV SPI reader
// ---------------------------------------------------------------------------
package pid_pkg;

    localparam int PV_W       = 8;
    localparam int PV_CLK_DIV = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } pv_state_e;

endpackage

// File: rtl/pv_spi_reader_if.sv
// ---------------------------------------------------------------------------
// pv_spi_reader_if
// Bundles the PV reader's control, sample and ADC-side SPI signals.
//   en, start         control from the PID core
//   pv_data, pv_valid sample delivered to the PID core
//   busy              reader is in a conversion
//   pv_in_clk/cs/miso SPI pins towards the ADC
//
// Handshake: start is a single-cycle request, taken only when the reader is
// idle and en is high; requests while busy are dropped, never queued.
// pv_valid is a one-cycle strobe with no backpressure: pv_data is new in
// that cycle and is held until the next strobe.
//
// modport master : the reader (drives SPI clock/select and the sample)
// modport slave  : the PID core / ADC side
// ---------------------------------------------------------------------------
interface pv_spi_reader_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              start;
    logic              pv_in_miso;
    logic              pv_in_clk;
    logic              pv_in_cs;
    logic [DATA_W-1:0] pv_data;
    logic              pv_valid;
    logic              busy;

    modport master (
        input  en, start, pv_in_miso,
        output pv_in_clk, pv_in_cs, pv_data, pv_valid, busy
    );

    modport slave (
        output en, start, pv_in_miso,
        input  pv_in_clk, pv_in_cs, pv_data, pv_valid, busy
    );
endinterface

// File: rtl/spi_sclk_div.sv
// ---------------------------------------------------------------------------
// spi_sclk_div
// Phase timer for an SPI master: splits time into phases of CLK_DIV system
// clock cycles while run is high. The first phase after run rises is a
// "low" phase, and phases then alternate low/high.
//   clk, reset  system clock, asynchronous active-low reset
//   run         timer enable; low clears counter and phase
//   phase_done  last cycle of the current phase
//   rise        last cycle of a low phase (SPI clock should go high next)
// ---------------------------------------------------------------------------
module spi_sclk_div
    import pid_pkg::*;
#(
    parameter int CLK_DIV = PV_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic phase_done,
    output logic rise
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          phase_high;

    assign phase_done = run && (cnt == LAST);
    assign rise       = phase_done && !phase_high;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            phase_high <= 1'b0;
        end else if (!run) begin
            cnt        <= '0;
            phase_high <= 1'b0;
        end else if (phase_done) begin
            cnt        <= '0;
            phase_high <= !phase_high;
        end else begin
            cnt        <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pv_spi_reader.sv
// ---------------------------------------------------------------------------
// pv_spi_reader
// SPI mode-0 master (MSB first) that reads one DATA_W-bit process-value
// sample from an ADC per start request and hands it to the PID core.
// Frame: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   clk        system clock
//   reset      asynchronous active-low reset
//   bus        pv_spi_reader_if master modport (en, start, SPI pins,
//              pv_data, pv_valid, busy); all outputs are registered
//   dbg_state  current FSM state
// Optional: define PV_AVG4_EN to deliver the truncated mean of every four
// completed frames instead of every frame.
// ---------------------------------------------------------------------------
module pv_spi_reader
    import pid_pkg::*;
#(
    parameter int DATA_W  = PV_W,
    parameter int CLK_DIV = PV_CLK_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    pv_spi_reader_if.master        bus,
    output pv_state_e              dbg_state
);

    localparam int             BCW      = $clog2(DATA_W + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    pv_state_e         state, state_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BCW-1:0]    bit_cnt, bit_cnt_d;
    logic              phase_done, rise;
    logic              run;

`ifdef PV_AVG4_EN
    localparam int AW = DATA_W + 2;
    logic [AW-1:0] acc, acc_d, acc_sum;
    logic [1:0]    frames, frames_d;
    assign acc_sum = acc + AW'(shreg);
`endif

    assign run = (state != IDLE);

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .phase_done (phase_done),
        .rise       (rise)
    );

    always_comb begin
        state_d   = state;
        sclk_d    = sclk_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
`ifdef PV_AVG4_EN
        acc_d     = acc;
        frames_d  = frames;
`endif
        if (!bus.en) begin
            // Abort (or stay idle): drop the frame, keep the last sample.
            state_d   = IDLE;
            sclk_d    = 1'b0;
            bit_cnt_d = '0;
`ifdef PV_AVG4_EN
            acc_d     = '0;
            frames_d  = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_d   = SETUP;
                        bit_cnt_d = '0;
                    end
                end
                SETUP: begin
                    // First rising SPI edge: capture the MSB the ADC put out
                    // when CS fell.
                    if (phase_done) begin
                        state_d = SHIFT;
                        sclk_d  = 1'b1;
                        shreg_d = {shreg[DATA_W-2:0], bus.pv_in_miso};
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        // End of a low phase: either the next bit's rising
                        // edge or, after the last bit, on to HOLD.
                        if (bit_cnt == LAST_BIT) begin
                            state_d   = HOLD;
                            sclk_d    = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            sclk_d    = 1'b1;
                            bit_cnt_d = bit_cnt + BCW'(1);
                            shreg_d   = {shreg[DATA_W-2:0], bus.pv_in_miso};
                        end
                    end else if (phase_done) begin
                        sclk_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        state_d = GAP;
`ifdef PV_AVG4_EN
                        if (frames == 2'd3) begin
                            valid_d  = 1'b1;
                            data_d   = acc_sum[AW-1:2];
                            acc_d    = '0;
                            frames_d = '0;
                        end else begin
                            acc_d    = acc_sum;
                            frames_d = frames + 2'd1;
                        end
`else
                        valid_d = 1'b1;
                        data_d  = shreg;
`endif
                    end
                end
                GAP: begin
                    if (phase_done) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        cs_d   = !(state_d inside {SETUP, SHIFT, HOLD});
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef PV_AVG4_EN
            acc     <= '0;
            frames  <= '0;
`endif
        end else begin
            state   <= state_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
`ifdef PV_AVG4_EN
            acc     <= acc_d;
            frames  <= frames_d;
`endif
        end
    end

    assign bus.pv_in_clk = sclk_q;
    assign bus.pv_in_cs  = cs_q;
    assign bus.busy      = busy_q;
    assign bus.pv_valid  = valid_q;
    assign bus.pv_data   = data_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_pv_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_pv_spi_reader
// Bench for pv_spi_reader: a default instance (DATA_W=8, CLK_DIV=2) and a
// DATA_W=12, CLK_DIV=1 instance, each fed by a mode-0 ADC model. Expected
// samples and their arrival cycles are queued when a start is driven and
// compared when pv_valid appears. Define PV_AVG4_EN for the averaging build.
// ---------------------------------------------------------------------------
module tb_pv_spi_reader;
    import pid_pkg::*;

    localparam int LAT8  = 1 + 2 + 2 * 2 * 8 + 2;   // 37
    localparam int LAT12 = 1 + 1 + 2 * 1 * 12 + 1; // 27

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pv_spi_reader_if #(.DATA_W(8))  bus8 ();
    pv_spi_reader_if #(.DATA_W(12)) bus12 ();
    pv_state_e st8, st12;

    pv_spi_reader u_dut (
        .clk(clk), .reset(reset), .bus(bus8), .dbg_state(st8)
    );
    pv_spi_reader #(.DATA_W(12), .CLK_DIV(1)) u_dut12 (
        .clk(clk), .reset(reset), .bus(bus12), .dbg_state(st12)
    );

    // ---------------- ADC models (shift on SPI falling edge) ----------------
    logic [7:0]  adc8_word  = 8'h00;
    logic [11:0] adc12_word = 12'h000;
    int          adc8_bit   = 7;
    int          adc12_bit  = 11;
    logic        prev8_clk  = 1'b0;
    logic        prev12_clk = 1'b0;

    always @(bus8.pv_in_cs, bus8.pv_in_clk) begin
        if (bus8.pv_in_cs) adc8_bit = 7;
        else if (prev8_clk && !bus8.pv_in_clk && adc8_bit > 0) adc8_bit = adc8_bit - 1;
        prev8_clk = bus8.pv_in_clk;
    end
    always @(bus12.pv_in_cs, bus12.pv_in_clk) begin
        if (bus12.pv_in_cs) adc12_bit = 11;
        else if (prev12_clk && !bus12.pv_in_clk && adc12_bit > 0) adc12_bit = adc12_bit - 1;
        prev12_clk = bus12.pv_in_clk;
    end
    assign bus8.pv_in_miso  = adc8_word[adc8_bit];
    assign bus12.pv_in_miso = adc12_word[adc12_bit];

    int rise8 = 0, rise12 = 0, last_rise12 = 0, prev_rise12 = 0;
    always @(posedge bus8.pv_in_clk) rise8++;
    always @(posedge bus12.pv_in_clk) begin
        rise12++;
        prev_rise12 = last_rise12;
        last_rise12 = cyc;
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0]  exp8_q[$];
    int          exp8_cyc_q[$];
    logic [11:0] exp12_q[$];
    int          exp12_cyc_q[$];
    int          acc8 = 0, n8 = 0, acc12 = 0, n12 = 0;
    logic [7:0]  last8 = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic frame_done8(input logic [7:0] w, input int sc);
`ifdef PV_AVG4_EN
        acc8 += int'(w);
        n8++;
        if (n8 == 4) begin
            last8 = 8'(acc8 / 4);
            exp8_q.push_back(last8);
            exp8_cyc_q.push_back(sc + LAT8);
            acc8 = 0;
            n8   = 0;
        end
`else
        last8 = w;
        exp8_q.push_back(w);
        exp8_cyc_q.push_back(sc + LAT8);
`endif
    endtask

    task automatic frame_done12(input logic [11:0] w, input int sc);
`ifdef PV_AVG4_EN
        acc12 += int'(w);
        n12++;
        if (n12 == 4) begin
            exp12_q.push_back(12'(acc12 / 4));
            exp12_cyc_q.push_back(sc + LAT12);
            acc12 = 0;
            n12   = 0;
        end
`else
        exp12_q.push_back(w);
        exp12_cyc_q.push_back(sc + LAT12);
`endif
    endtask

    // Output monitor: sample on the falling clock edge.
    int age8 = 0, age12 = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (age8 == 1) begin
                check_eq("busy8_valid_p1", bus8.busy, 1);
                age8 = 2;
            end else if (age8 == 2) begin
                check_eq("busy8_valid_p2", bus8.busy, 0);
                age8 = 0;
            end
            if (bus8.pv_valid) begin
                check_eq("valid8_expected", exp8_q.size() != 0, 1);
                if (exp8_q.size() != 0) begin
                    check_eq("data8", bus8.pv_data, exp8_q.pop_front());
                    check_eq("lat8", cyc, exp8_cyc_q.pop_front());
                end
                age8 = 1;
            end
            if (age12 == 1) begin
                check_eq("busy12_valid_p1", bus12.busy, 0);
                age12 = 0;
            end
            if (bus12.pv_valid) begin
                check_eq("valid12_expected", exp12_q.size() != 0, 1);
                if (exp12_q.size() != 0) begin
                    check_eq("data12", bus12.pv_data, exp12_q.pop_front());
                    check_eq("lat12", cyc, exp12_cyc_q.pop_front());
                end
                age12 = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start8(input logic [7:0] w, input bit completes, output int sc);
        @(negedge clk);
        adc8_word  = w;
        bus8.start = 1'b1;
        sc = cyc;
        if (completes) frame_done8(w, sc);
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic start12(input logic [11:0] w, output int sc);
        @(negedge clk);
        adc12_word  = w;
        bus12.start = 1'b1;
        sc = cyc;
        frame_done12(w, sc);
        @(negedge clk);
        bus12.start = 1'b0;
    endtask

    task automatic wait_idle8(input int budget);
        int n = 0;
        while (bus8.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle8_in_budget", bus8.busy, 0);
    endtask

    task automatic wait_idle12(input int budget);
        int n = 0;
        while (bus12.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle12_in_budget", bus12.busy, 0);
    endtask

    task automatic check_reset8(input string tag);
        check_eq({tag, "_sclk"},  bus8.pv_in_clk, 0);
        check_eq({tag, "_cs"},    bus8.pv_in_cs, 1);
        check_eq({tag, "_data"},  bus8.pv_data, 0);
        check_eq({tag, "_valid"}, bus8.pv_valid, 0);
        check_eq({tag, "_busy"},  bus8.busy, 0);
        check_eq({tag, "_state"}, st8, IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sc, rb;
        bus8.en = 1'b0;  bus8.start = 1'b0;
        bus12.en = 1'b0; bus12.start = 1'b0;
        tick(3);
        check_reset8("reset");
        check_eq("reset12_cs", bus12.pv_in_cs, 1);
        @(negedge clk);
        reset = 1'b1;
        bus8.en = 1'b1;
        bus12.en = 1'b1;
        tick(2);

        // Completed frame
        rb = rise8;
        start8(8'hA5, 1'b1, sc);
        check_eq("a5_cs_low", bus8.pv_in_cs, 0);
        check_eq("a5_busy", bus8.busy, 1);
        tick(18);
        check_eq("a5_cs_mid", bus8.pv_in_cs, 0);
        check_eq("a5_state_mid", st8, SHIFT);
        wait_idle8(100);
        check_eq("a5_sclk_rises", rise8 - rb, 8);

        // Start while busy is ignored
        start8(8'h3C, 1'b1, sc);
        tick(8);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_idle8(100);
        tick(6);
        check_eq("3c_no_second_frame", bus8.busy, 0);

        // Abort by en at cycle 15
        start8(8'h5A, 1'b0, sc);
        tick(14);
        bus8.en = 1'b0;
        @(negedge clk);
        check_eq("abort_cs", bus8.pv_in_cs, 1);
        check_eq("abort_sclk", bus8.pv_in_clk, 0);
        check_eq("abort_busy", bus8.busy, 0);
        check_eq("abort_state", st8, IDLE);
        check_eq("abort_data_kept", bus8.pv_data, last8);
        acc8 = 0;
        n8   = 0;
        bus8.en = 1'b1;
        tick(45);
        check_eq("abort_data_still", bus8.pv_data, last8);

        // Asynchronous reset in the middle of SHIFT
        start8(8'h66, 1'b0, sc);
        tick(10);
        #2 reset = 1'b0;
        #1 check_reset8("midrst");
        last8 = 8'h00;
        acc8 = 0; n8 = 0; acc12 = 0; n12 = 0;
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        start8(8'hFF, 1'b1, sc);
        wait_idle8(100);

        // Back-to-back random frames, then the averaging pattern
        for (int i = 0; i < 3; i++) begin
            start8(8'($urandom_range(0, 255)), 1'b1, sc);
            wait_idle8(100);
        end
        start8(8'h10, 1'b1, sc); wait_idle8(100);
        start8(8'h20, 1'b1, sc); wait_idle8(100);
        start8(8'h30, 1'b1, sc); wait_idle8(100);
        start8(8'h41, 1'b1, sc); wait_idle8(100);

        // 12-bit, CLK_DIV=1 instance
        rb = rise12;
        start12(12'h9F3, sc);
        wait_idle12(100);
        check_eq("w12_sclk_rises", rise12 - rb, 12);
        check_eq("w12_sclk_period", last_rise12 - prev_rise12, 2);
        for (int i = 0; i < 3; i++) begin
            start12(12'($urandom_range(0, 4095)), sc);
            wait_idle12(100);
        end

        tick(5);
        check_eq("exp8_drained", exp8_q.size(), 0);
        check_eq("exp12_drained", exp12_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
